// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: control FSM for a 16-step shift-and-add multiplier datapath.
// It captures an operand pair, sequences the LOAD / RUN / CAPT / DONE phases,
// and registers the final product from the datapath accumulator.
// Optional feature macro: SEQ_MULT_ZERO_SKIP_EN. When defined, a zero operand
// reported in LOAD skips the RUN phase. When undefined, empty is ignored.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH_M = 16,
  parameter int unsigned WIDTH_P = 32,
  parameter int unsigned WIDTH_C = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH_M-1:0] a_in,
  input  logic [WIDTH_M-1:0] b_in,
  output logic [WIDTH_M-1:0] dp_multiplier,
  output logic [WIDTH_M-1:0] dp_multiplicand,
  output logic               load_words,
  output logic               flush,
  output logic               add_shift,
  output logic               shift,
  input  logic               count_check,
  input  logic               empty,
  input  logic [WIDTH_P-1:0] product,
  output logic [WIDTH_P-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               seq_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [WIDTH_C-1:0] LAST_STEP = '1;

  state_e               state_q, state_d;
  logic [WIDTH_M-1:0]   opa_q, opa_d;
  logic [WIDTH_M-1:0]   opb_q, opb_d;
  logic [WIDTH_M-1:0]   mpl_q, mpl_d;
  logic [WIDTH_C-1:0]   cnt_q, cnt_d;
  logic [WIDTH_P-1:0]   result_q, result_d;
  logic                 seq_err_q, seq_err_d;
  logic                 start_ready_q, start_ready_d;
  logic                 busy_q, busy_d;
  logic                 load_words_q, load_words_d;
  logic                 flush_q, flush_d;
  logic                 add_shift_q, add_shift_d;
  logic                 shift_q, shift_d;
  logic                 result_valid_q, result_valid_d;
  logic                 last_step_c;

`ifndef SEQ_MULT_ZERO_SKIP_EN
  // empty has no effect without the zero-skip feature
  logic unused_empty_c;
  assign unused_empty_c = empty;
`endif

  assign last_step_c = (cnt_q == LAST_STEP);

  // Next-state, operand capture, step counting and registered-output decode
  always_comb begin
    state_d        = state_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    mpl_d          = mpl_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    seq_err_d      = seq_err_q;
    start_ready_d  = 1'b0;
    busy_d         = 1'b0;
    load_words_d   = 1'b0;
    flush_d        = 1'b0;
    add_shift_d    = 1'b0;
    shift_d        = 1'b0;
    result_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
          opa_d   = a_in;
          opb_d   = b_in;
          mpl_d   = a_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
`ifdef SEQ_MULT_ZERO_SKIP_EN
        if (empty) begin
          state_d = S_CAPT;
        end
`endif
      end
      S_RUN: begin
        // private multiplier copy exposes the next step's bit at its LSB
        mpl_d = mpl_q >> 1;
        cnt_d = cnt_q + WIDTH_C'(1);
        if (count_check != last_step_c) begin
          seq_err_d = 1'b1;
        end
        if (last_step_c) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        result_d = product;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (result_valid_q && result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so they line up with it
    start_ready_d  = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    load_words_d   = (state_d == S_LOAD);
    flush_d        = (state_d == S_LOAD);
    add_shift_d    = (state_d == S_RUN) &&  mpl_d[0];
    shift_d        = (state_d == S_RUN) && !mpl_d[0];
    // valid rises one cycle after DONE is entered and drops with the handshake
    result_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      opa_q          <= '0;
      opb_q          <= '0;
      mpl_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      seq_err_q      <= 1'b0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      load_words_q   <= 1'b0;
      flush_q        <= 1'b0;
      add_shift_q    <= 1'b0;
      shift_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      mpl_q          <= mpl_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      seq_err_q      <= seq_err_d;
      start_ready_q  <= start_ready_d;
      busy_q         <= busy_d;
      load_words_q   <= load_words_d;
      flush_q        <= flush_d;
      add_shift_q    <= add_shift_d;
      shift_q        <= shift_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready     = start_ready_q;
  assign busy            = busy_q;
  assign dp_multiplier   = opa_q;
  assign dp_multiplicand = opb_q;
  assign load_words      = load_words_q;
  assign flush           = flush_q;
  assign add_shift       = add_shift_q;
  assign shift           = shift_q;
  assign result          = result_q;
  assign result_valid    = result_valid_q;
  assign seq_err         = seq_err_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Testbench for seq_mult_ctrl with a behavioural shift-add datapath model.
module tb_seq_mult_ctrl;
  localparam int unsigned WM = 16;
  localparam int unsigned WP = 32;
  localparam int unsigned WC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_valid, start_ready;
  logic [WM-1:0] a_in, b_in, dp_multiplier, dp_multiplicand;
  logic          load_words, flush, add_shift, shift, count_check, empty;
  logic [WP-1:0] product, result;
  logic          result_valid, result_ready, busy, seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_ctrl #(.WIDTH_M(WM), .WIDTH_P(WP), .WIDTH_C(WC)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .dp_multiplier(dp_multiplier),
    .dp_multiplicand(dp_multiplicand), .load_words(load_words), .flush(flush),
    .add_shift(add_shift), .shift(shift), .count_check(count_check), .empty(empty),
    .product(product), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .seq_err(seq_err)
  );

  // Datapath model: accumulator, shifting multiplicand and step counter
  logic [WP-1:0] acc, mc;
  logic [4:0]    dcnt;
  logic          force_cc;
  always @(posedge clk) begin
    if (!reset) begin
      acc <= '0; mc <= '0; dcnt <= '0;
    end else if (load_words) begin
      acc <= '0; mc <= {16'h0000, dp_multiplicand}; dcnt <= '0;
    end else if (add_shift) begin
      acc <= acc + mc; mc <= mc << 1; dcnt <= dcnt + 5'd1;
    end else if (shift) begin
      mc <= mc << 1; dcnt <= dcnt + 5'd1;
    end
  end
  assign product     = acc;
  assign count_check = force_cc | (dcnt == 5'd15);
  assign empty       = (dp_multiplier == '0) || (dp_multiplicand == '0);

  // Pulse monitor: cumulative totals plus per-operation add_shift step mask
  int          tot_add = 0, tot_shift = 0, tot_both = 0, tot_bad = 0;
  logic [15:0] add_mask = '0;
  logic [4:0]  mstep = '0;
  always @(posedge clk) begin
    if (add_shift) tot_add <= tot_add + 1;
    if (shift) tot_shift <= tot_shift + 1;
    if (add_shift && shift) tot_both <= tot_both + 1;
    if ((load_words || flush || add_shift || shift) && (result_valid || start_ready))
      tot_bad <= tot_bad + 1;
    if (load_words) begin
      add_mask <= '0; mstep <= '0;
    end else if (add_shift || shift) begin
      if (add_shift) add_mask[mstep[3:0]] <= 1'b1;
      mstep <= mstep + 5'd1;
    end
  end

  // Offer an operand pair from a negedge; returns at the negedge after the accept edge
  task automatic do_accept(input logic [WM-1:0] a, input logic [WM-1:0] b, output bit ok);
    ok = 1'b0;
    start_valid = 1'b1; a_in = a; b_in = b;
    for (int i = 0; i < 40; i++) begin
      if (start_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Step negedges until result_valid; idx is the cycle index counted from the accept edge
  task automatic wait_valid(input int start, output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (result_valid === 1'b1) begin idx = start + i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start_valid = 1'b0; a_in = '0; b_in = '0;
    result_ready = 1'b0; force_cc = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL rst_start_ready: got %b want 1", start_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", result_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_seq_err: got %b want 0", seq_err); end
    n_checks++; if ({load_words, flush, add_shift, shift} !== 4'b0000) begin n_fail++; $display("FAIL rst_ctrls: got %b want 0000", {load_words, flush, add_shift, shift}); end
    n_checks++; if (dp_multiplier !== 16'h0) begin n_fail++; $display("FAIL rst_operand: got %h want 0", dp_multiplier); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int idx; bit ok; int a0, s0, b0, k0;
    result_ready = 1'b1;
    a0 = tot_add; s0 = tot_shift; b0 = tot_both; k0 = tot_bad;
    do_accept(16'd3, 16'd5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept: start_ready got 0 want 1"); end
    n_checks++; if ({busy, load_words, flush} !== 3'b111) begin n_fail++; $display("FAIL basic_load: got %b want 111", {busy, load_words, flush}); end
    wait_valid(0, idx);
    n_checks++; if (idx != 19) begin n_fail++; $display("FAIL basic_latency: got %0d want 19", idx); end
    n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL basic_result: got %0d want 15", result); end
    n_checks++; if (add_mask !== 16'h0003) begin n_fail++; $display("FAIL basic_add_mask: got %h want 0003", add_mask); end
    n_checks++; if (tot_add - a0 != 2 || tot_shift - s0 != 14) begin n_fail++; $display("FAIL basic_pulses: got add %0d shift %0d want 2 14", tot_add - a0, tot_shift - s0); end
    n_checks++; if (tot_both != b0 || tot_bad != k0) begin n_fail++; $display("FAIL basic_ctrl_overlap: got both %0d bad %0d want 0 0", tot_both - b0, tot_bad - k0); end
    @(negedge clk);
    n_checks++; if ({result_valid, start_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL basic_return_idle: got %b want 010", {result_valid, start_ready, busy}); end
  endtask

  task automatic test_max();
    int idx; bit ok; int a0, s0;
    a0 = tot_add; s0 = tot_shift;
    do_accept(16'hFFFF, 16'hFFFF, ok);
    wait_valid(0, idx);
    n_checks++; if (!ok || idx != 19) begin n_fail++; $display("FAIL max_latency: got %0d want 19", idx); end
    n_checks++; if (result !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_result: got %h want fffe0001", result); end
    n_checks++; if (tot_add - a0 != 16 || tot_shift - s0 != 0) begin n_fail++; $display("FAIL max_pulses: got add %0d shift %0d want 16 0", tot_add - a0, tot_shift - s0); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL max_seq_err: got %b want 0", seq_err); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int idx; bit ok; int a0, s0;
    a0 = tot_add; s0 = tot_shift;
    do_accept(16'h0000, 16'h1234, ok);
    wait_valid(0, idx);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    n_checks++; if (!ok || idx != 3) begin n_fail++; $display("FAIL zero_latency: got %0d want 3", idx); end
    n_checks++; if (tot_add - a0 != 0 || tot_shift - s0 != 0) begin n_fail++; $display("FAIL zero_pulses: got add %0d shift %0d want 0 0", tot_add - a0, tot_shift - s0); end
`else
    n_checks++; if (!ok || idx != 19) begin n_fail++; $display("FAIL zero_latency: got %0d want 19", idx); end
    n_checks++; if (tot_add - a0 != 0 || tot_shift - s0 != 16) begin n_fail++; $display("FAIL zero_pulses: got add %0d shift %0d want 0 16", tot_add - a0, tot_shift - s0); end
`endif
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL zero_result: got %h want 0", result); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int idx; bit ok;
    result_ready = 1'b0;
    do_accept(16'd7, 16'd9, ok);
    wait_valid(0, idx);
    n_checks++; if (!ok || idx != 19) begin n_fail++; $display("FAIL bp_latency: got %0d want 19", idx); end
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; a_in = 16'd2; b_in = 16'd2;
      @(negedge clk);
      n_checks++; if (result !== 32'd63) begin n_fail++; $display("FAIL bp_result_hold: got %0d want 63", result); end
      n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b want 1", result_valid); end
      n_checks++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL bp_start_ready: got %b want 0", start_ready); end
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({result_valid, start_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b want 01", {result_valid, start_ready}); end
    n_checks++; if (dp_multiplier !== 16'd7 || dp_multiplicand !== 16'd9) begin n_fail++; $display("FAIL bp_no_recapture: got %h %h want 0007 0009", dp_multiplier, dp_multiplicand); end
  endtask

  task automatic test_reset_mid();
    int idx; bit ok; int seen;
    do_accept(16'd5, 16'd6, ok);
    repeat (9) @(negedge clk);
    n_checks++; if (!ok || busy !== 1'b1 || (add_shift ^ shift) !== 1'b1) begin n_fail++; $display("FAIL rm_in_run: got busy %b add %b shift %b want running", busy, add_shift, shift); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++; if ({busy, result_valid, start_ready} !== 3'b001) begin n_fail++; $display("FAIL rm_abort: got %b want 001", {busy, result_valid, start_ready}); end
    n_checks++; if ({load_words, flush, add_shift, shift} !== 4'b0000) begin n_fail++; $display("FAIL rm_ctrls: got %b want 0000", {load_words, flush, add_shift, shift}); end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (result_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rm_no_result: got %0d active cycles want 0", seen); end
    do_accept(16'd4, 16'd4, ok);
    wait_valid(0, idx);
    n_checks++; if (!ok || idx != 19) begin n_fail++; $display("FAIL rm_new_latency: got %0d want 19", idx); end
    n_checks++; if (result !== 32'd16) begin n_fail++; $display("FAIL rm_new_result: got %0d want 16", result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int idx; bit ok;
    result_ready = 1'b1;
    do_accept(16'h1234, 16'h0010, ok);
    wait_valid(0, idx);
    n_checks++; if (!ok || idx != 19) begin n_fail++; $display("FAIL b2b_latency0: got %0d want 19", idx); end
    n_checks++; if (result !== 32'h00012340) begin n_fail++; $display("FAIL b2b_result0: got %h want 00012340", result); end
    do_accept(16'h8000, 16'h0002, ok);
    n_checks++; if (!ok || dp_multiplicand !== 16'h0002) begin n_fail++; $display("FAIL b2b_capture1: got %h want 0002", dp_multiplicand); end
    wait_valid(0, idx);
    n_checks++; if (idx != 19) begin n_fail++; $display("FAIL b2b_latency1: got %0d want 19", idx); end
    n_checks++; if (result !== 32'h00010000) begin n_fail++; $display("FAIL b2b_result1: got %h want 00010000", result); end
    @(negedge clk);
  endtask

  task automatic test_seq_err();
    int idx; bit ok;
    result_ready = 1'b1;
    do_accept(16'd6, 16'd7, ok);
    n_checks++; if (!ok || seq_err !== 1'b0) begin n_fail++; $display("FAIL se_initial: got %b want 0", seq_err); end
    repeat (4) @(negedge clk);
    force_cc = 1'b1;
    @(negedge clk);
    force_cc = 1'b0;
    n_checks++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL se_set: got %b want 1", seq_err); end
    wait_valid(5, idx);
    n_checks++; if (idx != 19) begin n_fail++; $display("FAIL se_latency: got %0d want 19", idx); end
    n_checks++; if (result !== 32'd42) begin n_fail++; $display("FAIL se_result: got %0d want 42", result); end
    @(negedge clk);
    n_checks++; if (seq_err !== 1'b1 || start_ready !== 1'b1) begin n_fail++; $display("FAIL se_sticky: got err %b ready %b want 1 1", seq_err, start_ready); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL se_clear: got %b want 0", seq_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_seq_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001: Parameters SHALL be: WIDTH_M, 16, operand width; WIDTH_P, 32, product width; WIDTH_C, 4, step-count width.
REQ-002: clk  input  1  single clock; all logic on rising edge.
REQ-003: reset  input  1  reset, synchronous, active-low.
REQ-004: start_valid  input  1  operand pair offered.
REQ-005: start_ready  output  1  controller can accept an operand pair.
REQ-006: a_in, b_in  input  WIDTH_M each  multiplier and multiplicand; sampled on the accept edge.
REQ-007: dp_multiplier, dp_multiplicand  output  WIDTH_M each  captured operands driven to the datapath.
REQ-008: load_words, flush, add_shift, shift  output  1 each  datapath controls.
REQ-009: count_check  input  1  datapath step counter equals 15.
REQ-010: empty  input  1  datapath reports a zero operand.
REQ-011: product  input  WIDTH_P  datapath accumulator.
REQ-012: result  output  WIDTH_P  registered final product.
REQ-013: result_valid  output  1  result available; result_ready  input  1  consumer accepts.
REQ-014: busy  output  1  state is not IDLE; seq_err  output  1  sticky step-count mismatch flag.

Function
REQ-015: FSM states SHALL be IDLE, LOAD, RUN, CAPT, DONE.
REQ-016: IDLE: start_ready=1; start_valid&start_ready at an edge captures a_in/b_in into operand registers and enters LOAD.
REQ-017: start_ready SHALL be 0 in every state except IDLE; start_valid outside IDLE is ignored and operands are not recaptured.
REQ-018: LOAD: exactly one cycle with load_words=1 and flush=1; next state RUN (see REQ-030 for the exception).
REQ-019: Controller SHALL keep a private copy of the multiplier, shifted right by one each RUN cycle, and a 4-bit local step counter cleared in LOAD.
REQ-020: RUN: each cycle asserts exactly one of add_shift (private multiplier LSB=1) or shift (LSB=0); they are never both high.
REQ-021: RUN lasts exactly 16 cycles; leave to CAPT on the cycle where the local step counter is 15.
REQ-022: If count_check differs from (local step counter==15) in any RUN cycle, seq_err SHALL set and stay set until reset; sequencing still follows the local counter.
REQ-023: CAPT: one cycle, result<=product; next DONE.
REQ-024: DONE: result_valid=1 and result held stable; result_valid&result_ready returns to IDLE the next cycle.
REQ-025: Latency: accept at edge E0 -> result_valid first high in the cycle after edge E19 (1 LOAD + 16 RUN + 1 CAPT + 1).
REQ-026: load_words, flush, add_shift and shift SHALL be 0 in IDLE, CAPT and DONE.
REQ-027: result SHALL be the low WIDTH_P bits of a_in*b_in, with no truncation for 16x16.

Reset
REQ-028: While reset=0 at an edge: state<=IDLE, operand registers, result, step counter and seq_err<=0; after that edge result_valid=0 and all datapath controls=0.
REQ-029: Reset asserted mid-operation (any state) SHALL abort without producing result_valid; start_ready returns to 1 on the first cycle after reset is released. reset is shared with the datapath.

Configuration
REQ-030: Macro SEQ_MULT_ZERO_SKIP_EN defined: in LOAD, empty=1 sends the FSM to CAPT (not RUN); result is 0 and result_valid first goes high 3 cycles after the accept edge. No add_shift or shift pulses are issued.
REQ-031: Macro undefined: empty SHALL be ignored; zero operands take the full 16-step sequence of REQ-025 and give result 0.

Verification
REQ-032: a=3, b=5, result_ready=1 -> result=15; result_valid high in the cycle after edge E19; add_shift pulses in RUN steps 0 and 1 only.
REQ-033: a=0xFFFF, b=0xFFFF -> result=0xFFFE0001; 16 add_shift pulses, 0 shift pulses; seq_err=0.
REQ-034: a=0, b=0x1234 -> with SEQ_MULT_ZERO_SKIP_EN: result=0 and valid 3 cycles after accept; without the macro: result=0 and valid per REQ-025.
REQ-035: a=7, b=9, result_ready held low 5 cycles into DONE -> result=63 is held stable; start_ready=0 throughout; start_valid with a=2, b=2 during this period is ignored.
REQ-036: reset pulled low at RUN step 8, then released -> busy=0, result_valid=0, start_ready=1; a new request a=4, b=4 then returns 16.
REQ-037: count_check forced high at RUN step 3 -> seq_err=1 and stays at 1; result is still correct; seq_err clears only on reset.
